uart_mem_dump: RTL

UART_MEM_DUMP -- requirements
Module: uart_mem_dump

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 65 ++++++
 rtl/uart_mem_dump.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART frame constants and the memory-dump FSM state encoding.
// The CSUM state and byte-sum helper exist only with UART_DUMP_CHECKSUM_EN defined.
package uart_pkg;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam int   UART_FRAME_BITS = 10;

`ifdef UART_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, LOAD, SEND, NEXT, CSUM} dump_state_t;

  // Modulo-256 sum of the four bytes of a memory word
  function automatic logic [7:0] word_byte_sum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, LOAD, SEND, NEXT} dump_state_t;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready handshake; ready also rises in the last
// stop-bit cycle so a following byte can start with no idle gap. BAUD_DIV >= 2.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] data,
  output logic       tx
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(UART_FRAME_BITS - 1);
  localparam logic [3:0] BIT_LAST_DATA = 4'(UART_FRAME_BITS - 2);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic             last_cycle;

  assign last_cycle = active && (baud_cnt == BAUD_LAST) && (bit_cnt == BIT_LAST);
  assign ready      = !active || last_cycle;

  // The line level for the next bit is registered at the end of the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= UART_STOP_BIT;
    end else if (valid && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= data;
      tx       <= UART_START_BIT;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == BIT_LAST_DATA) begin
            tx <= UART_STOP_BIT;
          end else begin
            tx    <= shift[0];
            shift <= shift >> 1;
          end
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// Reads consecutive 32-bit words from a synchronous RAM and sends each LSB-first
// over an 8N1 UART; UART_DUMP_CHECKSUM_EN appends a modulo-256 byte-sum frame.
module uart_mem_dump
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 87,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [ADDR_W:0]   word_cnt_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  input  logic [31:0]       mem_dat_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              done_o
);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remain;
  logic [23:0]       word_hi;
  logic [1:0]        byte_idx;
  logic              done_q, done_nxt;
  logic              tx_valid, tx_ready;
  logic [7:0]        tx_data;
  logic              last_word;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign last_word = (remain == (ADDR_W + 1)'(1));
  assign mem_rd_o  = (state == READ);
  assign mem_adr_o = addr;
  assign busy_o    = (state != IDLE);
  assign done_o    = done_q;

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst),
    .valid (tx_valid),
    .ready (tx_ready),
    .data  (tx_data),
    .tx    (uart_tx_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  // The first byte of a word is handed over in WAIT straight from the RAM output
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = word_hi[7:0];
    case (state)
      IDLE: begin
        if (start_i) begin
          if (word_cnt_i != '0) state_nxt = READ;
          else                  done_nxt  = 1'b1;
        end
      end
      READ: state_nxt = WAIT;
      WAIT: begin
        tx_valid  = 1'b1;
        tx_data   = mem_dat_i[7:0];
        state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (tx_ready) begin
          if (byte_idx != 2'd3) begin
            tx_valid = 1'b1;
          end else if (!last_word) begin
            state_nxt = NEXT;
          end else begin
`ifdef UART_DUMP_CHECKSUM_EN
            tx_valid  = 1'b1;
            tx_data   = csum;
            state_nxt = CSUM;
`else
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`endif
          end
        end
      end
      NEXT: state_nxt = READ;
`ifdef UART_DUMP_CHECKSUM_EN
      CSUM: begin
        if (tx_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      remain   <= '0;
      word_hi  <= '0;
      byte_idx <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (state == IDLE && start_i) begin
        addr   <= base_adr_i;
        remain <= word_cnt_i;
`ifdef UART_DUMP_CHECKSUM_EN
        csum   <= '0;
`endif
      end
      if (state == WAIT) begin
        word_hi  <= mem_dat_i[31:8];
        byte_idx <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
        csum     <= csum + word_byte_sum(mem_dat_i);
`endif
      end
      if (state == SEND && tx_valid) begin
        word_hi  <= word_hi >> 8;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == NEXT) begin
        addr   <= addr + ADDR_W'(1);
        remain <= remain - (ADDR_W + 1)'(1);
      end
    end
  end

endmodule
